// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states and
// the datapath mux / ALU select codes.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b000101;
  localparam logic [5:0] OP_ANDI = 6'b000110;
  localparam logic [5:0] OP_LW   = 6'b000111;
  localparam logic [5:0] OP_SW   = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_BNE  = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b001011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_SEXT = 2'b01;
  localparam logic [1:0] SRCB_ZEXT = 2'b10;
  localparam logic [1:0] SRCB_INC  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] PWC_EN = 2'b01;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: post-DECODE state, ALU function, immediate
// extension select and branch polarity.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output state_e     next_state,
  output logic [2:0] alu_op,
  output logic [1:0] srcb_imm,
  output logic       branch_sel,
  output logic       is_rtype,
  output logic       legal
);

  always_comb begin
    next_state = FETCH;
    alu_op     = ALU_ADD;
    srcb_imm   = SRCB_SEXT;
    branch_sel = 1'b0;
    is_rtype   = 1'b0;
    legal      = 1'b1;
    case (op)
      OP_ADD:  begin next_state = EXEC_R; is_rtype = 1'b1; end
      OP_SUB:  begin next_state = EXEC_R; is_rtype = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin next_state = EXEC_R; is_rtype = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin next_state = EXEC_R; is_rtype = 1'b1; alu_op = ALU_OR;  end
      OP_ADDI: next_state = EXEC_I;
      OP_ANDI: begin next_state = EXEC_I; alu_op = ALU_AND; srcb_imm = SRCB_ZEXT; end
      OP_LW, OP_SW: next_state = MEM_ADDR;
      OP_BEQ:  begin next_state = BRANCH; alu_op = ALU_SUB; end
      OP_BNE:  begin next_state = BRANCH; alu_op = ALU_SUB; branch_sel = 1'b1; end
      OP_J:    next_state = JUMP;
      OP_HALT: next_state = HALT;
      default: legal = 1'b0;  // falls back to FETCH: executes as a NOP
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM: one state per datapath cycle, outputs decoded
// from the state register, plus retired-count and sticky halt/illegal status.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             CtrlOp,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic [1:0]             PCWriteCond,
  output logic                   BranchSel,
  output logic                   PCWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   ReadDst,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   halted,
  output logic                   illegal_op
);

  state_e                 state_q, state_d;
  logic [5:0]             op_q, op_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   halted_q, halted_d;
  logic                   illegal_q, illegal_d;

  logic [5:0] dec_op;
  state_e     dec_next;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_srcb_imm;
  logic       dec_branch_sel, dec_rtype, dec_legal;

  // Live opcode only while decoding; afterwards the latched copy steers execution.
  assign dec_op = (state_q == DECODE) ? CtrlOp : op_q;

  mc_op_decode u_dec (
    .op         (dec_op),
    .next_state (dec_next),
    .alu_op     (dec_alu_op),
    .srcb_imm   (dec_srcb_imm),
    .branch_sel (dec_branch_sel),
    .is_rtype   (dec_rtype),
    .legal      (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      op_q      <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      INIT:   state_d = FETCH;
      FETCH: begin
        state_d = DECODE;
        cnt_d   = cnt_q + COUNT_WIDTH'(1);
      end
      DECODE: begin
        op_d    = CtrlOp;
        state_d = dec_next;
        if (!dec_legal)       illegal_d = 1'b1;
        if (dec_next == HALT) halted_d  = 1'b1;
      end
      EXEC_R, EXEC_I: state_d = ALU_WB;
      MEM_ADDR:       state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:         state_d = MEM_WB;
      ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP: state_d = FETCH;
      HALT:           state_d = HALT;
      default:        state_d = INIT;
    endcase
  end

  always_comb begin
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    PCSource    = PCS_ALU;
    PCWriteCond = 2'b00;
    BranchSel   = 1'b0;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ReadDst     = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_INC;
      end
      DECODE: begin
        ALUSrcB = SRCB_SEXT;  // branch target precomputed into ALUOut
        ReadDst = dec_rtype;
      end
      EXEC_R: begin
        ALUSrcA = SRCA_A;
        ReadDst = 1'b1;
        ALUOp   = dec_alu_op;
      end
      EXEC_I: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = dec_srcb_imm;
        ALUOp   = dec_alu_op;
      end
      ALU_WB:   RegWrite = 1'b1;
      MEM_ADDR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_SEXT;
      end
      MEM_RD:   MemRead = 1'b1;
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEM_WR:   MemWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = SRCA_A;
        ALUOp       = ALU_SUB;
        PCWriteCond = PWC_EN;
        PCSource    = PCS_ALUOUT;
        BranchSel   = dec_branch_sel;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      default: ;
    endcase
  end

  assign instr_count = cnt_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: the driver queues hand-tabled control
// words per cycle, the monitor pops and compares them on the falling edge.
module tb_mc_control_fsm;

  localparam int CW = 4;

  localparam int T_INIT = 0, T_FETCH = 1, T_DECODE = 2, T_EXR = 3, T_EXI = 4,
                 T_AWB = 5, T_MA = 6, T_MR = 7, T_MWB = 8, T_MWR = 9,
                 T_BR = 10, T_J = 11, T_HALT = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    CtrlOp;
  logic [1:0]    ALUSrcA, ALUSrcB, PCSource, PCWriteCond;
  logic [2:0]    ALUOp;
  logic          BranchSel, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, ReadDst;
  logic [CW-1:0] instr_count;
  logic          halted, illegal_op;

  mc_control_fsm #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .CtrlOp(CtrlOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .PCWriteCond(PCWriteCond), .BranchSel(BranchSel), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ReadDst(ReadDst), .instr_count(instr_count),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] v;
    int          st;
    logic [5:0]  op;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_halt = 1'b0;
  logic          exp_ill = 1'b0;

  // Hand table of control words, packed {SrcA,SrcB,ALUOp,PCSrc,PWC,BSel,PCW,IRW,RW,MR,MW,M2R,RD}.
  function automatic logic [18:0] ctl(input int st, input logic [5:0] op);
    logic [1:0] a, b, pcs, pwc;
    logic [2:0] alu;
    logic       bs, pw, irw, rw, mr, mw, m2r, rd;
    {a, b, pcs, pwc, alu, bs, pw, irw, rw, mr, mw, m2r, rd} = '0;
    case (st)
      T_FETCH:  begin irw = 1; pw = 1; b = 2'b11; end
      T_DECODE: begin b = 2'b01; rd = (op == 6'b000001 || op == 6'b000010 ||
                                       op == 6'b000011 || op == 6'b000100); end
      T_EXR: begin
        a = 2'b01; rd = 1;
        case (op)
          6'b000010: alu = 3'b001;
          6'b000011: alu = 3'b010;
          6'b000100: alu = 3'b011;
          default:   alu = 3'b000;
        endcase
      end
      T_EXI: begin
        a = 2'b01;
        if (op == 6'b000110) begin b = 2'b10; alu = 3'b010; end
        else b = 2'b01;
      end
      T_AWB: rw = 1;
      T_MA:  begin a = 2'b01; b = 2'b01; end
      T_MR:  mr = 1;
      T_MWB: begin rw = 1; m2r = 1; end
      T_MWR: mw = 1;
      T_BR:  begin a = 2'b01; alu = 3'b001; pwc = 2'b01; pcs = 2'b01; bs = (op == 6'b001010); end
      T_J:   begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {a, b, alu, pcs, pwc, bs, pw, irw, rw, mr, mw, m2r, rd};
  endfunction

  task automatic push(input int st, input logic [5:0] op);
    exp_t e;
    e.v  = {ctl(st, op), exp_cnt, exp_halt, exp_ill};
    e.st = st;
    e.op = op;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH to its last state; CtrlOp is scrambled after DECODE.
  task automatic instr(input logic [5:0] op, input int stop_at_mr);
    int seq[$];
    CtrlOp = op;
    push(T_FETCH, op);  step(); exp_cnt = exp_cnt + 1'b1;
    push(T_DECODE, op); step();
    case (op)
      6'b000001, 6'b000010, 6'b000011, 6'b000100: seq = '{T_EXR, T_AWB};
      6'b000101, 6'b000110: seq = '{T_EXI, T_AWB};
      6'b000111: seq = (stop_at_mr != 0) ? '{T_MA} : '{T_MA, T_MR, T_MWB};
      6'b001000: seq = '{T_MA, T_MWR};
      6'b001001, 6'b001010: seq = '{T_BR};
      6'b001011: seq = '{T_J};
      6'b111111: begin
        exp_halt = 1'b1;
        for (int i = 0; i < 20; i++) seq.push_back(T_HALT);
      end
      default: exp_ill = 1'b1;
    endcase
    CtrlOp = ~op;
    foreach (seq[i]) begin
      push(seq[i], op);
      step();
    end
  endtask

  task automatic reset_into_init();
    exp_cnt = '0; exp_halt = 1'b0; exp_ill = 1'b0;
    reset = 1'b0;
    push(T_INIT, 6'b0);
    step();
  endtask

  always @(negedge clk) begin
    logic [24:0] act;
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWriteCond, BranchSel, PCWrite, IRWrite,
             RegWrite, MemRead, MemWrite, MemtoReg, ReadDst, instr_count, halted, illegal_op};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL ctl st=%0d op=%b: got %h expected %h", e.st, e.op, act, e.v);
      end
      checks++;
      if (($countones({RegWrite, MemWrite, IRWrite}) > 1) !== 1'b0) begin
        errors++;
        $display("FAIL write_onehot st=%0d: got RW/MW/IRW=%b expected at most one set",
                 e.st, {RegWrite, MemWrite, IRWrite});
      end
    end
  end

  initial begin
    reset  = 1'b1;
    CtrlOp = 6'b000001;
    step();
    push(T_INIT, 6'b0); step();
    push(T_INIT, 6'b0); step();
    reset_into_init();

    instr(6'b000001, 0);
    instr(6'b000111, 0);
    instr(6'b001000, 0);
    instr(6'b001010, 0);
    instr(6'b001001, 0);
    instr(6'b000101, 0);
    instr(6'b000110, 0);
    instr(6'b000010, 0);
    instr(6'b000011, 0);
    instr(6'b000100, 0);
    instr(6'b001011, 0);

    instr(6'b010101, 0);
    instr(6'b000001, 0); instr(6'b000010, 0); instr(6'b000011, 0);
    instr(6'b000100, 0); instr(6'b000101, 0); instr(6'b000110, 0);
    instr(6'b000111, 0); instr(6'b001000, 0); instr(6'b001001, 0);
    instr(6'b001011, 0);

    // Reset landing in the middle of a load.
    instr(6'b000111, 1);
    reset = 1'b1;
    push(T_MR, 6'b000111);
    step();
    reset_into_init();

    // Sixteen fetches from zero wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) instr(6'b001011, 0);
    push(T_FETCH, 6'b001011); step();
    exp_cnt = exp_cnt + 1'b1;

    CtrlOp = 6'b111111;
    push(T_DECODE, 6'b111111); step();
    exp_halt = 1'b1;
    CtrlOp = 6'b000001;
    for (int i = 0; i < 20; i++) begin push(T_HALT, 6'b111111); step(); end
    reset = 1'b1;
    push(T_HALT, 6'b111111);
    step();
    reset_into_init();
    instr(6'b000001, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: got %0d entries pending expected 0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
